systolic_tile_ctrl: RTL

//   Sequences one output tile on the ARRAY_N x ARRAY_N weight/activation systolic PE array.
//   Per tile it:
//     - issues K reads to the A (activation) and B (weight) tile buffers;
//     - emits the accumulator-clear pulse aligned with the first operand;
//     - flushes the skewed wavefront;
//     - drains results row by row over a valid/ready port.

---
 rtl/systolic_tile_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/systolic_tile_ctrl.sv
// systolic_tile_ctrl: sequences one output tile on the ARRAY_N x ARRAY_N PE array.
// A tile runs IDLE -> FEED (k_len operand reads) -> FLUSH (skew drain) ->
// DRAIN (one result row per valid/ready handshake) -> DONE -> IDLE.
// Every output comes straight from a flop. The flops load from the next-state
// values, so each output lines up with the state it describes.
module systolic_tile_ctrl #(
  parameter int ARRAY_N = 4,
  parameter int K_W     = 8,
  parameter int ADDR_W  = 16,
  localparam int ROW_W  = (ARRAY_N > 1) ? $clog2(ARRAY_N) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [K_W-1:0]    k_len,
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  output logic              a_rd_en,
  output logic [ADDR_W-1:0] a_rd_addr,
  output logic              b_rd_en,
  output logic [ADDR_W-1:0] b_rd_addr,
  output logic              feed_valid,
  output logic              pe_rst,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ROW_W-1:0]  res_row,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_FLUSH = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // The flush covers the skewed wavefront: 2*ARRAY_N+1 cycles, counted 0..2*ARRAY_N.
  localparam int FLUSH_W = $clog2(2 * ARRAY_N + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(2 * ARRAY_N);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ARRAY_N - 1);

  logic [2:0]         state, state_n;
  logic [K_W-1:0]     k_cnt, k_cnt_n;
  logic [K_W-1:0]     k_len_q, k_len_n;
  logic [FLUSH_W-1:0] flush_cnt, flush_cnt_n;
  logic [ROW_W-1:0]   row, row_n;
  logic               launch;
  logic               err_n;

  // Next-state and counter update for the tile sequencer
  always_comb begin
    state_n     = state;
    k_cnt_n     = k_cnt;
    k_len_n     = k_len_q;
    flush_cnt_n = flush_cnt;
    row_n       = row;
    launch      = 1'b0;
    err_n       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (k_len != '0) begin
            state_n = S_FEED;
            k_cnt_n = '0;
            k_len_n = k_len;
            launch  = 1'b1;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      S_FEED: begin
        if (k_cnt == k_len_q - K_W'(1)) begin
          state_n     = S_FLUSH;
          flush_cnt_n = '0;
        end else begin
          k_cnt_n = k_cnt + K_W'(1);
        end
      end
      S_FLUSH: begin
        if (flush_cnt == FLUSH_LAST) begin
          state_n = S_DRAIN;
          row_n   = '0;
        end else begin
          flush_cnt_n = flush_cnt + FLUSH_W'(1);
        end
      end
      S_DRAIN: begin
        if (res_valid && res_ready) begin
          if (row == ROW_LAST) begin
            state_n = S_DONE;
          end else begin
            row_n = row + ROW_W'(1);
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Sequencer state and internal counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k_cnt     <= '0;
      k_len_q   <= '0;
      flush_cnt <= '0;
      row       <= '0;
    end else begin
      state     <= state_n;
      k_cnt     <= k_cnt_n;
      k_len_q   <= k_len_n;
      flush_cnt <= flush_cnt_n;
      row       <= row_n;
    end
  end

  // Buffer read port: addresses start at the sampled base and step once per FEED cycle, wrapping freely
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rd_en   <= 1'b0;
      b_rd_en   <= 1'b0;
      a_rd_addr <= '0;
      b_rd_addr <= '0;
    end else begin
      a_rd_en <= (state_n == S_FEED);
      b_rd_en <= (state_n == S_FEED);
      if (launch) begin
        a_rd_addr <= a_base;
        b_rd_addr <= b_base;
      end else if (state_n == S_FEED) begin
        a_rd_addr <= a_rd_addr + ADDR_W'(1);
        b_rd_addr <= b_rd_addr + ADDR_W'(1);
      end else begin
        a_rd_addr <= '0;
        b_rd_addr <= '0;
      end
    end
  end

  // Operand valid follows the one-cycle buffer latency; the clear pulse marks its rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feed_valid <= 1'b0;
      pe_rst     <= 1'b0;
    end else begin
      feed_valid <= a_rd_en;
      pe_rst     <= a_rd_en && !feed_valid;
    end
  end

  // Result port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_row   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      res_valid <= (state_n == S_DRAIN);
      res_row   <= (state_n == S_DRAIN) ? row_n : '0;
      busy      <= (state_n != S_IDLE);
      done      <= (state_n == S_DONE);
      err       <= err_n;
    end
  end

endmodule
